// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver.
//   state_t       : controller states
//   EXC_TBL_HOLD  : {J,K} codes indexed by {cur,tgt}, don't-cares filled with 0
//   EXC_TBL_TOGGLE: {J,K} codes indexed by {cur,tgt}, don't-cares filled with 1
//   CNT_W         : settle counter width (SETTLE legal range 0..15)
package jk_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_WAIT  = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   localparam int CNT_W = 4;

   // Packed as [7:6]=11, [5:4]=10, [3:2]=01, [1:0]=00 where the index is
   // {cur,tgt}. Each 2-bit entry is {J,K}.
   localparam logic [7:0] EXC_TBL_HOLD   = {2'b00, 2'b01, 2'b10, 2'b00};
   localparam logic [7:0] EXC_TBL_TOGGLE = {2'b10, 2'b11, 2'b11, 2'b01};

   function automatic logic [1:0] exc_code(input logic cur, input logic tgt,
                                           input logic dc_fill);
      logic [7:0] tbl;
      int         idx;
      tbl = dc_fill ? EXC_TBL_TOGGLE : EXC_TBL_HOLD;
      idx = {30'd0, cur, tgt} * 2;
      return tbl[idx +: 2];
   endfunction

endpackage

// File: rtl/jk_excitation_driver_excite.sv
// Purely combinational JK excitation: for every bit, the {J,K} pair that
// moves a JK flip-flop from cur to tgt on its next clock.
//   cur : current Q of each flip-flop
//   tgt : desired Q of each flip-flop
//   j,k : excitation inputs for the bank
module jk_excite
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter bit DC_FILL = 1'b0
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] tgt,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k
);

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [1:0] code;
      assign code = exc_code(cur[b], tgt[b], DC_FILL);
      assign j[b] = code[1];
      assign k[b] = code[0];
   end

endmodule

// File: rtl/jk_excitation_driver.sv
// JK excitation driver: takes a target word, drives the JK bank for one
// cycle with the excitation that reaches it, holds for SETTLE cycles, then
// reads the bank back and flags any bit that missed.
//   clk, rst_n          : clock, async active-low reset
//   tgt_valid/tgt_ready : target handshake (ready only in IDLE)
//   tgt_data            : desired bank state
//   Q_fb                : bank state feedback
//   J, K                : registered bank excitation
//   busy                : transaction in progress
//   done, err           : readback pulse and its mismatch flag
//   err_mask            : per-bit mismatch of the last readback (held)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a target, J=K=0
// S_DRIVE | one cycle of excitation on J/K
// S_WAIT  | J=K=0 for SETTLE cycles while the bank settles
// S_CHECK | done pulse, readback result registered
module jk_excitation_driver
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int SETTLE  = 2,
   parameter bit DC_FILL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic [WIDTH-1:0] Q_fb,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] err_mask
);

   localparam logic [CNT_W-1:0] SETTLE_LD =
      (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

   state_t             state;
   logic [CNT_W-1:0]   settle_cnt;
   logic [WIDTH-1:0]   tgt_r;
   logic [WIDTH-1:0]   cur_r;
   logic [WIDTH-1:0]   cur_d;
   logic [WIDTH-1:0]   tgt_d;
   logic [WIDTH-1:0]   exc_j;
   logic [WIDTH-1:0]   exc_k;
   logic [WIDTH-1:0]   miss;

   assign tgt_ready = (state == S_IDLE);

   // The excitation is evaluated on the values being captured, so J/K can be
   // registered on the accept edge and present for the whole DRIVE cycle.
   assign cur_d = tgt_ready ? Q_fb     : cur_r;
   assign tgt_d = tgt_ready ? tgt_data : tgt_r;

   jk_excite #(
      .WIDTH   (WIDTH),
      .DC_FILL (DC_FILL)
   ) u_excite (
      .cur (cur_d),
      .tgt (tgt_d),
      .j   (exc_j),
      .k   (exc_k)
   );

   assign miss = Q_fb ^ tgt_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         settle_cnt <= '0;
         tgt_r      <= '0;
         cur_r      <= '0;
         J          <= '0;
         K          <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_mask   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               J    <= '0;
               K    <= '0;
               done <= 1'b0;
               err  <= 1'b0;
               if (tgt_valid) begin
                  tgt_r <= tgt_data;
                  cur_r <= Q_fb;
                  J     <= exc_j;
                  K     <= exc_k;
                  busy  <= 1'b1;
                  state <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               J          <= '0;
               K          <= '0;
               settle_cnt <= SETTLE_LD;
               if (SETTLE == 0) begin
                  // Readback result is registered on the edge entering
                  // CHECK so err/err_mask are valid alongside done.
                  done     <= 1'b1;
                  err      <= |miss;
                  err_mask <= miss;
                  state    <= S_CHECK;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               J <= '0;
               K <= '0;
               if (settle_cnt == '0) begin
                  done     <= 1'b1;
                  err      <= |miss;
                  err_mask <= miss;
                  state    <= S_CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            S_CHECK: begin
               J     <= '0;
               K     <= '0;
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               J     <= '0;
               K     <= '0;
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_excitation_driver.sv
module tb_jk_excitation_driver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Index 0: SETTLE=2 DC_FILL=0; 1: SETTLE=2 DC_FILL=1; 2: SETTLE=0 DC_FILL=0
   int settle_of[3] = '{2, 2, 0};
   bit dcf_of[3]    = '{1'b0, 1'b1, 1'b0};

   logic       tv[3];
   logic [3:0] td[3];
   logic [3:0] qfb[3];
   logic [3:0] jo[3];
   logic [3:0] ko[3];
   logic [3:0] em[3];
   logic       tr[3];
   logic       bz[3];
   logic       dn[3];
   logic       er[3];

   jk_excitation_driver #(.WIDTH(4), .SETTLE(2), .DC_FILL(1'b0)) u_d0 (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tv[0]), .tgt_ready(tr[0]),
      .tgt_data(td[0]), .Q_fb(qfb[0]), .J(jo[0]), .K(ko[0]), .busy(bz[0]),
      .done(dn[0]), .err(er[0]), .err_mask(em[0]));

   jk_excitation_driver #(.WIDTH(4), .SETTLE(2), .DC_FILL(1'b1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tv[1]), .tgt_ready(tr[1]),
      .tgt_data(td[1]), .Q_fb(qfb[1]), .J(jo[1]), .K(ko[1]), .busy(bz[1]),
      .done(dn[1]), .err(er[1]), .err_mask(em[1]));

   jk_excitation_driver #(.WIDTH(4), .SETTLE(0), .DC_FILL(1'b0)) u_d2 (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tv[2]), .tgt_ready(tr[2]),
      .tgt_data(td[2]), .Q_fb(qfb[2]), .J(jo[2]), .K(ko[2]), .busy(bz[2]),
      .done(dn[2]), .err(er[2]), .err_mask(em[2]));

   // JK bank model: J/K registered on one edge, Q updates on the next.
   logic [3:0] bq[3];
   logic [3:0] bj[3];
   logic [3:0] bk[3];
   logic       ld[3];
   logic [3:0] ld_val[3];
   logic [3:0] stuck[3];

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         bj[i] <= jo[i];
         bk[i] <= ko[i];
         if (ld[i]) bq[i] <= ld_val[i];
         else       bq[i] <= (bj[i] & ~bq[i]) | (~bk[i] & bq[i]);
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) qfb[i] = bq[i] & ~stuck[i];
   end

   typedef struct packed { logic [3:0] j; logic [3:0] k; } jk_t;
   typedef struct packed { logic e; logic [3:0] m; } res_t;
   jk_t  jk_q[$];
   res_t res_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic jk_t exc(input logic [3:0] c, input logic [3:0] t, input bit dcf);
      jk_t r;
      if (dcf) begin
         r.j = c | t;
         r.k = ~(c & t);
      end else begin
         r.j = ~c & t;
         r.k = c & ~t;
      end
      return r;
   endfunction

   task automatic txn(input int s, input logic [3:0] cur, input logic [3:0] tgt,
                      input logic [3:0] stk, input bit hold);
      jk_t  ej;
      res_t ex;
      logic [3:0] seen;
      int cyc;
      bit got;
      stuck[s] = stk;
      @(negedge clk);
      ld[s] = 1'b1;
      ld_val[s] = cur;
      @(negedge clk);
      ld[s] = 1'b0;
      chk("ready_idle", 32'(tr[s]), 32'd1);
      jk_q.push_back(exc(cur, tgt, dcf_of[s]));
      seen = (settle_of[s] == 0) ? (cur & ~stk) : (tgt & ~stk);
      ex.m = seen ^ tgt;
      ex.e = |ex.m;
      res_q.push_back(ex);
      tv[s] = 1'b1;
      td[s] = tgt;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (hold) td[s] = ~tgt ^ 4'(cyc);
         else      tv[s] = 1'b0;
         chk("ready_busy", 32'(tr[s]), 32'd0);
         chk("busy", 32'(bz[s]), 32'd1);
         if (cyc == 1) begin
            ej = jk_q.pop_front();
            chk("drive_j", 32'(jo[s]), 32'(ej.j));
            chk("drive_k", 32'(ko[s]), 32'(ej.k));
         end else begin
            chk("hold_jk", 32'({jo[s], ko[s]}), 32'd0);
         end
         if (dn[s]) got = 1'b1;
      end
      tv[s] = 1'b0;
      if (!got) begin
         chk("done_timeout", 32'd0, 32'd1);
         void'(res_q.pop_front());
      end else begin
         chk("latency", 32'(cyc), 32'(2 + settle_of[s]));
         ex = res_q.pop_front();
         chk("err", 32'(er[s]), 32'(ex.e));
         chk("err_mask", 32'(em[s]), 32'(ex.m));
      end
      @(negedge clk);
      chk("ready_after", 32'(tr[s]), 32'd1);
      chk("done_pulse", 32'(dn[s]), 32'd0);
      chk("busy_after", 32'(bz[s]), 32'd0);
      if (got) chk("mask_held", 32'(em[s]), 32'(ex.m));
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         tv[i] = 1'b0;
         td[i] = '0;
         ld[i] = 1'b0;
         ld_val[i] = '0;
         stuck[i] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bz[0]), 32'd0);
      chk("rst_jk", 32'({jo[0], ko[0]}), 32'd0);
      chk("rst_done", 32'(dn[0]), 32'd0);
      chk("rst_mask", 32'(em[0]), 32'd0);
      chk("rst_ready", 32'(tr[0]), 32'd1);
      rst_n = 1'b1;

      txn(0, 4'b0011, 4'b0101, 4'b0000, 1'b0);
      txn(1, 4'b0011, 4'b0101, 4'b0000, 1'b0);
      chk("dc1_model_q", 32'(bq[1]), 32'h5);
      txn(1, 4'b1010, 4'b1010, 4'b0000, 1'b0);
      txn(0, 4'b0000, 4'b0100, 4'b0100, 1'b0);

      // Reset in the middle of WAIT on instance 0 (err_mask is 0100 here).
      @(negedge clk);
      tv[0] = 1'b1;
      td[0] = 4'b1010;
      @(negedge clk);
      tv[0] = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", 32'(bz[0]), 32'd1);
      chk("pre_rst_mask", 32'(em[0]), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", 32'(bz[0]), 32'd0);
      chk("async_jk", 32'({jo[0], ko[0]}), 32'd0);
      chk("async_done", 32'(dn[0]), 32'd0);
      chk("async_err", 32'(er[0]), 32'd0);
      chk("async_mask", 32'(em[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(tr[0]), 32'd1);
      chk("rel_busy", 32'(bz[0]), 32'd0);

      txn(0, 4'b1100, 4'b0110, 4'b0000, 1'b1);
      txn(2, 4'b0110, 4'b0110, 4'b0000, 1'b0);
      txn(2, 4'b0001, 4'b1000, 4'b0000, 1'b0);

      for (int n = 0; n < 4; n++) begin
         txn(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'b0000, 1'b0);
         txn(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'b0000, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
